// File: rtl/tern_pkg.sv
// Shared ternary-weight types, code constants and quantize/decode helpers.
package tern_pkg;

  typedef logic [1:0] tern_code_t;

  localparam tern_code_t TERN_ZERO = 2'b00;
  localparam tern_code_t TERN_POS  = 2'b01;
  localparam tern_code_t TERN_NEG  = 2'b11;

  typedef enum logic [0:0] {
    StEmpty,
    StFill
  } pack_state_e;

  // Operands are ints, so -thresh never overflows for any legal sample width.
  function automatic tern_code_t tern_quant(input int sample, input int thresh);
    if (sample >= thresh) begin
      return TERN_POS;
    end else if (sample <= -thresh) begin
      return TERN_NEG;
    end else begin
      return TERN_ZERO;
    end
  endfunction

  function automatic logic tern_is_nz(input tern_code_t code);
    return code != TERN_ZERO;
  endfunction

  // Consumer-side decode: 00 -> 0, 01 -> +1, anything else -> -1.
  function automatic logic signed [1:0] tern_decode(input tern_code_t code);
    if (code == TERN_ZERO) begin
      return 2'sd0;
    end else if (code == TERN_POS) begin
      return 2'sd1;
    end else begin
      return -2'sd1;
    end
  endfunction

endpackage

// File: rtl/ternary_quant_packer_if.sv
// Sample-in / packed-word-out handshake bundle for the ternary packer.
interface ternary_quant_packer_if #(
  parameter int unsigned DATA_W = 3,
  parameter int unsigned LANES  = 4
);
  localparam int unsigned CNT_W = $clog2(LANES + 1);

  logic                     in_vld;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_last;
  logic                     in_rdy;
  logic                     out_vld;
  logic [2*LANES-1:0]       out_codes;
  logic [CNT_W-1:0]         out_cnt;
  logic [CNT_W-1:0]         out_nz;
  logic                     out_rdy;

  // Sample producer and word consumer side.
  modport master (
    output in_vld, in_data, in_last, out_rdy,
    input  in_rdy, out_vld, out_codes, out_cnt, out_nz
  );

  // The packer itself.
  modport slave (
    input  in_vld, in_data, in_last, out_rdy,
    output in_rdy, out_vld, out_codes, out_cnt, out_nz
  );
endinterface

// File: rtl/ternary_quant_packer_quant_lane.sv
// Combinational sample -> ternary code quantizer with nonzero flag.
module tern_quant_lane
  import tern_pkg::*;
#(
  parameter int unsigned DATA_W = 3,
  parameter int unsigned THRESH = 1
) (
  input  logic signed [DATA_W-1:0] sample,
  output tern_code_t               code,
  output logic                     nz
);

  int sample_ext;

  // Sign-extend to int so the -THRESH compare cannot wrap at DATA_W bits.
  always_comb begin
    sample_ext = int'(sample);
    code       = tern_quant(sample_ext, int'(THRESH));
    nz         = tern_is_nz(code);
  end

endmodule

// File: rtl/ternary_quant_packer.sv
// Quantizes a signed sample stream to ternary codes and packs LANES codes per word.
module ternary_quant_packer
  import tern_pkg::*;
#(
  parameter int unsigned DATA_W = 3,
  parameter int unsigned LANES  = 4,
  parameter int unsigned THRESH = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  ternary_quant_packer_if.slave  bus
);

  localparam int unsigned CNT_W  = $clog2(LANES + 1);
  localparam int unsigned LANE_W = $clog2(LANES);
  localparam int unsigned WORD_W = 2 * LANES;

  pack_state_e       state_q, state_d;
  logic [LANE_W-1:0] lane_cnt_q, lane_cnt_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  acc_nz_q, acc_nz_d;
  logic              out_vld_q, out_vld_d;
  logic [WORD_W-1:0] out_codes_q, out_codes_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0]  out_nz_q, out_nz_d;

  tern_code_t        code;
  logic              code_nz;
  logic              accept;
  logic              last_lane;
  logic              complete;
  logic [WORD_W-1:0] merged;
  logic [CNT_W-1:0]  merged_nz;

  tern_quant_lane #(
    .DATA_W (DATA_W),
    .THRESH (THRESH)
  ) u_quant_lane (
    .sample (bus.in_data),
    .code   (code),
    .nz     (code_nz)
  );

  // A stalled output word blocks intake, which also freezes the accumulator.
  assign bus.in_rdy = !out_vld_q || bus.out_rdy;
  assign accept     = bus.in_vld && bus.in_rdy;
  assign last_lane  = lane_cnt_q == LANE_W'(LANES - 1);
  assign complete   = accept && (last_lane || bus.in_last);

  assign bus.out_vld   = out_vld_q;
  assign bus.out_codes = out_codes_q;
  assign bus.out_cnt   = out_cnt_q;
  assign bus.out_nz    = out_nz_q;

  // Accumulator with the incoming code placed in lane lane_cnt_q; upper lanes stay zero.
  always_comb begin
    merged = acc_q;
    for (int i = 0; i < int'(LANES); i++) begin
      if (lane_cnt_q == LANE_W'(i)) begin
        merged[2*i +: 2] = code;
      end
    end
    merged_nz = acc_nz_q + CNT_W'(code_nz);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a word completing on its first sample never leaves StEmpty.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (accept && !complete) state_d = StFill;
      StFill:  if (complete) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  // Datapath next values: lane fill, word emission and output hold/drop.
  always_comb begin
    lane_cnt_d  = lane_cnt_q;
    acc_d       = acc_q;
    acc_nz_d    = acc_nz_q;
    out_vld_d   = out_vld_q;
    out_codes_d = out_codes_q;
    out_cnt_d   = out_cnt_q;
    out_nz_d    = out_nz_q;

    if (accept) begin
      if (complete) begin
        lane_cnt_d = '0;
        acc_d      = '0;
        acc_nz_d   = '0;
      end else begin
        lane_cnt_d = lane_cnt_q + LANE_W'(1);
        acc_d      = merged;
        acc_nz_d   = merged_nz;
      end
    end

    // A new word overwrites one being handed off in the same cycle, so no bubble.
    if (complete) begin
      out_vld_d   = 1'b1;
      out_codes_d = merged;
      out_cnt_d   = CNT_W'(lane_cnt_q) + CNT_W'(1);
      out_nz_d    = merged_nz;
    end else if (out_vld_q && bus.out_rdy) begin
      out_vld_d = 1'b0;
    end
  end

  // Datapath registers; reset discards any partial fill and any pending word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_cnt_q  <= '0;
      acc_q       <= '0;
      acc_nz_q    <= '0;
      out_vld_q   <= 1'b0;
      out_codes_q <= '0;
      out_cnt_q   <= '0;
      out_nz_q    <= '0;
    end else begin
      lane_cnt_q  <= lane_cnt_d;
      acc_q       <= acc_d;
      acc_nz_q    <= acc_nz_d;
      out_vld_q   <= out_vld_d;
      out_codes_q <= out_codes_d;
      out_cnt_q   <= out_cnt_d;
      out_nz_q    <= out_nz_d;
    end
  end

  // A stalled word must stay put until the consumer takes it.
  assert property (@(posedge clk) disable iff (!rst_n)
    (out_vld_q && !bus.out_rdy) |=>
      (out_vld_q && $stable(out_codes_q) && $stable(out_cnt_q) && $stable(out_nz_q)));

  // StEmpty always means no lanes are pending.
  assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StEmpty) |-> (lane_cnt_q == '0));

  // The reserved code 2'b10 is never emitted.
  for (genvar g = 0; g < int'(LANES); g++) begin : g_lane_legal
    assert property (@(posedge clk) disable iff (!rst_n)
      out_vld_q |-> (out_codes_q[2*g +: 2] != 2'b10));
  end

endmodule

// File: tb/tb_ternary_quant_packer.sv
// Scoreboard bench for ternary_quant_packer: THRESH=1 and THRESH=2 instances.
module tb_ternary_quant_packer;
  import tern_pkg::*;

  typedef struct packed {
    logic [7:0] codes;
    logic [2:0] cnt;
    logic [2:0] nz;
  } word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en2 = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  word_t exp_q1[$];
  word_t exp_q2[$];
  word_t e1, e2;
  longint t0;

  always #5 clk = ~clk;

  ternary_quant_packer_if #(.DATA_W(3), .LANES(4)) ifc ();
  ternary_quant_packer_if #(.DATA_W(3), .LANES(4)) ifc2 ();

  // Second instance shares the sample bus but only sees samples while en2 is set.
  assign ifc2.in_vld  = ifc.in_vld & en2;
  assign ifc2.in_data = ifc.in_data;
  assign ifc2.in_last = ifc.in_last;
  assign ifc2.out_rdy = 1'b1;

  ternary_quant_packer #(.DATA_W(3), .LANES(4), .THRESH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  ternary_quant_packer #(.DATA_W(3), .LANES(4), .THRESH(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push1(input logic [7:0] c, input logic [2:0] n, input logic [2:0] z);
    word_t w;
    w = '{codes: c, cnt: n, nz: z};
    exp_q1.push_back(w);
  endtask

  task automatic push2(input logic [7:0] c, input logic [2:0] n, input logic [2:0] z);
    word_t w;
    w = '{codes: c, cnt: n, nz: z};
    exp_q2.push_back(w);
  endtask

  // Present a sample and return 1 time unit after the edge that accepts it.
  task automatic send(input int d, input logic last);
    int waited = 0;
    ifc.in_vld  = 1'b1;
    ifc.in_data = 3'(d);
    ifc.in_last = last;
    @(negedge clk);
    while (!ifc.in_rdy && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!ifc.in_rdy) begin
      n_checks++;
      n_fail++;
      $display("FAIL send timeout: in_rdy stuck at 0 for sample %0d", d);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor for the THRESH=1 instance.
  always @(negedge clk) begin
    if (rst_n && ifc.out_vld && ifc.out_rdy) begin
      if (exp_q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut1 unexpected word: got 0x%0h, expected none", ifc.out_codes);
      end else begin
        e1 = exp_q1.pop_front();
        chk("dut1 out_codes", 32'(ifc.out_codes), 32'(e1.codes));
        chk("dut1 out_cnt", 32'(ifc.out_cnt), 32'(e1.cnt));
        chk("dut1 out_nz", 32'(ifc.out_nz), 32'(e1.nz));
      end
    end
  end

  // Monitor for the THRESH=2 instance.
  always @(negedge clk) begin
    if (rst_n && ifc2.out_vld && ifc2.out_rdy) begin
      if (exp_q2.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut2 unexpected word: got 0x%0h, expected none", ifc2.out_codes);
      end else begin
        e2 = exp_q2.pop_front();
        chk("dut2 out_codes", 32'(ifc2.out_codes), 32'(e2.codes));
        chk("dut2 out_cnt", 32'(ifc2.out_cnt), 32'(e2.cnt));
        chk("dut2 out_nz", 32'(ifc2.out_nz), 32'(e2.nz));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.in_vld  = 1'b0;
    ifc.in_data = '0;
    ifc.in_last = 1'b0;
    ifc.out_rdy = 1'b1;

    // Reset state.
    #2;
    chk("reset outputs", {31'(0), ifc.out_vld}, 32'd0);
    chk("reset word", {18'(0), ifc.out_codes, ifc.out_cnt, ifc.out_nz}, 32'd0);
    #15 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_rdy after reset", 32'(ifc.in_rdy), 32'd1);

    // 3,-4,0,1 -> lanes 01,11,00,01.
    push1(8'h4D, 3'd4, 3'd3);
    send(3, 1'b0);
    send(-4, 1'b0);
    send(0, 1'b0);
    send(1, 1'b0);
    chk("word latency out_vld", 32'(ifc.out_vld), 32'd1);
    ifc.in_vld = 1'b0;
    @(posedge clk);
    #1;
    chk("out_vld single cycle", 32'(ifc.out_vld), 32'd0);

    // 1,-2,2,-1: THRESH=1 gives 01,11,01,11; THRESH=2 gives 00,11,01,00.
    en2 = 1'b1;
    push1(8'hDD, 3'd4, 3'd4);
    push2(8'h1C, 3'd4, 3'd2);
    send(1, 1'b0);
    send(-2, 1'b0);
    send(2, 1'b0);
    send(-1, 1'b0);
    ifc.in_vld = 1'b0;
    en2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Flush a 2-lane word, then a 1-lane word that must restart at lane 0.
    push1(8'h0D, 3'd2, 3'd2);
    push1(8'h01, 3'd1, 3'd1);
    send(2, 1'b0);
    send(-1, 1'b1);
    send(1, 1'b1);
    ifc.in_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: 1,0,0,-1 -> 11_00_00_01, then hold with a sample waiting.
    ifc.out_rdy = 1'b0;
    push1(8'hC1, 3'd4, 3'd2);
    send(1, 1'b0);
    send(0, 1'b0);
    send(0, 1'b0);
    send(-1, 1'b0);
    ifc.in_vld  = 1'b1;
    ifc.in_data = 3'sd1;
    ifc.in_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall hold {vld,rdy,codes,cnt,nz}",
          {18'(0), ifc.out_vld, ifc.in_rdy, ifc.out_codes, ifc.out_cnt, ifc.out_nz},
          {18'(0), 1'b1, 1'b0, 8'hC1, 3'd4, 3'd2});
    end
    @(posedge clk);
    #1;
    ifc.out_rdy = 1'b1;
    #1;
    chk("in_rdy follows out_rdy", 32'(ifc.in_rdy), 32'd1);
    @(posedge clk);
    #1;
    // Waiting sample 1 went in at lane 0; no lane advanced during the stall.
    push1(8'h0D, 3'd2, 3'd2);
    send(-1, 1'b1);
    ifc.in_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Streaming -4..3: two full words with one accept per cycle.
    push1(8'hFF, 3'd4, 3'd4);
    push1(8'h54, 3'd4, 3'd3);
    t0 = $time;
    for (int d = -4; d <= 3; d++) begin
      send(d, 1'b0);
    end
    chk("stream cycles for 8 samples", 32'(($time - t0) / 10), 32'd8);
    ifc.in_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-fill after -1,-1; without the reset the next word would be 0x5F.
    send(-1, 1'b0);
    send(-1, 1'b0);
    ifc.in_vld = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset clears outputs",
        {21'(0), ifc.out_vld, ifc.out_codes, ifc.out_cnt, ifc.out_nz}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    push1(8'h55, 3'd4, 3'd4);
    send(1, 1'b0);
    send(1, 1'b0);
    send(1, 1'b0);
    send(1, 1'b0);
    ifc.in_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    chk("dut1 words outstanding", 32'(exp_q1.size()), 32'd0);
    chk("dut2 words outstanding", 32'(exp_q2.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
